// File: rtl/dp_ctrl_fsm.sv
// Multi-cycle control FSM for the ARM data-processing datapath.
// Sequences FETCH/DECODE/EXEC/WB and drives datapath enables and selects from IR.
module dp_ctrl_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] IR,
    input  logic [3:0]  NZCV,
    output logic        Write_PC,
    output logic        Write_IR,
    output logic        Write_Reg,
    output logic        LA,
    output logic        LB,
    output logic        LC,
    output logic        LF,
    output logic        rm_imm_s,
    output logic [1:0]  rs_imm_s,
    output logic [3:0]  ALU_OP,
    output logic [2:0]  SHIFT_OP,
    output logic        S,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic        undef,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t      r_state, w_next, w_boundary;
    logic [15:0] r_retired;
    logic        w_undef_ir, w_cond_pass, w_is_cmp;
    logic        w_rm_sel;
    logic [1:0]  w_rs_sel;
    logic [2:0]  w_shift_sel;

    logic w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = NZCV;

    assign w_undef_ir = (IR[27:26] != 2'b00)
                      | (~IR[25] & IR[7] & IR[4])
                      | ((IR[24:23] == 2'b10) & ~IR[20]);
    assign w_is_cmp   = (IR[24:23] == 2'b10);
    assign w_boundary = run ? S_FETCH : S_IDLE;

    always_comb begin
        w_cond_pass = 1'b0;
        case (IR[31:28])
            4'b0000: w_cond_pass = w_z;
            4'b0001: w_cond_pass = ~w_z;
            4'b0010: w_cond_pass = w_c;
            4'b0011: w_cond_pass = ~w_c;
            4'b0100: w_cond_pass = w_n;
            4'b0101: w_cond_pass = ~w_n;
            4'b0110: w_cond_pass = w_v;
            4'b0111: w_cond_pass = ~w_v;
            4'b1000: w_cond_pass = w_c & ~w_z;
            4'b1001: w_cond_pass = ~w_c | w_z;
            4'b1010: w_cond_pass = (w_n == w_v);
            4'b1011: w_cond_pass = (w_n != w_v);
            4'b1100: w_cond_pass = ~w_z & (w_n == w_v);
            4'b1101: w_cond_pass = w_z | (w_n != w_v);
            4'b1110: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    // Operand/shift selects depend only on IR so WB can hold the EXEC values.
    always_comb begin
        w_rm_sel    = 1'b0;
        w_rs_sel    = 2'b00;
        w_shift_sel = 3'b000;
        if (IR[25]) begin
            w_rm_sel    = 1'b1;
            w_rs_sel    = 2'b10;
            w_shift_sel = 3'b111;
        end else if (!IR[4]) begin
            w_rs_sel    = 2'b01;
            w_shift_sel = {IR[6:5], 1'b0};
        end else begin
            w_rs_sel    = 2'b00;
            w_shift_sel = {IR[6:5], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_retired <= 16'd0;
        end else begin
            r_state <= w_next;
            if (instr_done)
                r_retired <= r_retired + 16'd1;
        end
    end

    always_comb begin
        w_next     = S_IDLE;
        Write_PC   = 1'b0;
        Write_IR   = 1'b0;
        Write_Reg  = 1'b0;
        LA         = 1'b0;
        LB         = 1'b0;
        LC         = 1'b0;
        LF         = 1'b0;
        rm_imm_s   = 1'b0;
        rs_imm_s   = 2'b00;
        ALU_OP     = 4'b0000;
        SHIFT_OP   = 3'b000;
        S          = 1'b0;
        instr_done = 1'b0;
        undef      = 1'b0;
        case (r_state)
            S_IDLE: w_next = run ? S_FETCH : S_IDLE;
            S_FETCH: begin
                Write_IR = 1'b1;
                Write_PC = 1'b1;
                w_next   = S_DECODE;
            end
            S_DECODE: begin
                LA = 1'b1;
                LB = 1'b1;
                LC = 1'b1;
                if (w_undef_ir) begin
                    undef  = 1'b1;
                    w_next = w_boundary;
                end else if (!w_cond_pass) begin
                    instr_done = 1'b1;
                    w_next     = w_boundary;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                LF       = 1'b1;
                S        = IR[20];
                ALU_OP   = IR[24:21];
                rm_imm_s = w_rm_sel;
                rs_imm_s = w_rs_sel;
                SHIFT_OP = w_shift_sel;
                if (w_is_cmp) begin
                    instr_done = 1'b1;
                    w_next     = w_boundary;
                end else begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                Write_Reg  = 1'b1;
                ALU_OP     = IR[24:21];
                rm_imm_s   = w_rm_sel;
                rs_imm_s   = w_rs_sel;
                SHIFT_OP   = w_shift_sel;
                instr_done = 1'b1;
                w_next     = w_boundary;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign state   = r_state;
    assign retired = r_retired;

endmodule

// File: tb/tb_dp_ctrl_fsm.sv
// Bench for dp_ctrl_fsm: phase-based instruction model checked every cycle,
// plus directed instruction vectors with hand-computed expectations.
module tb_dp_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n, run;
    logic [31:0] IR;
    logic [3:0]  NZCV;
    logic        Write_PC, Write_IR, Write_Reg, LA, LB, LC, LF, rm_imm_s, S;
    logic [1:0]  rs_imm_s;
    logic [3:0]  ALU_OP;
    logic [2:0]  SHIFT_OP, state;
    logic        instr_done, undef;
    logic [15:0] retired;

    int checks = 0;
    int failures = 0;

    dp_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .run(run), .IR(IR), .NZCV(NZCV),
        .Write_PC(Write_PC), .Write_IR(Write_IR), .Write_Reg(Write_Reg),
        .LA(LA), .LB(LB), .LC(LC), .LF(LF),
        .rm_imm_s(rm_imm_s), .rs_imm_s(rs_imm_s), .ALU_OP(ALU_OP),
        .SHIFT_OP(SHIFT_OP), .S(S), .state(state),
        .instr_done(instr_done), .undef(undef), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [22:0] w_outs;
    assign w_outs = {Write_PC, Write_IR, Write_Reg, LA, LB, LC, LF, rm_imm_s,
                     rs_imm_s, ALU_OP, SHIFT_OP, S, state, instr_done, undef};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic is_undef(input logic [31:0] ir);
        return (ir[27:26] != 2'b00) || (!ir[25] && ir[7] && ir[4]) ||
               (ir[24:23] == 2'b10 && !ir[20]);
    endfunction

    // Conditions come in complementary pairs: even code tests, odd code inverts.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        {n, z, cy, v} = f;
        r = 1'b0;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: return (c[0] == 1'b0);
        endcase
        return c[0] ? !r : r;
    endfunction

    // Number of cycles from FETCH through the retiring/skipping state.
    function automatic int ilen(input logic [31:0] ir, input logic [3:0] f);
        if (is_undef(ir) || !cond_ok(ir[31:28], f)) return 2;
        if (ir[24:23] == 2'b10) return 3;
        return 4;
    endfunction

    function automatic logic [22:0] exp_outs(input int ph, input logic [31:0] ir, input logic [3:0] f);
        logic wpc, wir, wreg, la, lb, lc, lf, rm, s, done, und;
        logic [1:0] rs;
        logic [3:0] alu;
        logic [2:0] sh;
        int len;
        {wpc, wir, wreg, la, lb, lc, lf, rm, s, done, und} = '0;
        rs = 2'b00; alu = 4'b0000; sh = 3'b000;
        len = ilen(ir, f);
        if (ph == 1) begin wpc = 1'b1; wir = 1'b1; end
        if (ph == 2) begin
            {la, lb, lc} = 3'b111;
            und  = is_undef(ir);
            done = (len == 2) && !und;
        end
        if (ph == 3 || ph == 4) begin
            alu = ir[24:21];
            if (ir[25]) begin rm = 1'b1; rs = 2'b10; sh = 3'b111; end
            else begin rs = ir[4] ? 2'b00 : 2'b01; sh = {ir[6:5], ir[4]}; end
        end
        if (ph == 3) begin lf = 1'b1; s = ir[20]; done = (len == 3); end
        if (ph == 4) begin wreg = 1'b1; done = 1'b1; end
        return {wpc, wir, wreg, la, lb, lc, lf, rm, rs, alu, sh, s, ph[2:0], done, und};
    endfunction

    int          m_ph;
    logic [15:0] m_ret;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph  <= 0;
            m_ret <= 16'd0;
        end else if (m_ph == 0) begin
            m_ph <= run ? 1 : 0;
        end else if (m_ph == ilen(IR, NZCV)) begin
            m_ph <= run ? 1 : 0;
            if (!is_undef(IR)) m_ret <= m_ret + 16'd1;
        end else begin
            m_ph <= m_ph + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_outs", {9'd0, w_outs}, {9'd0, exp_outs(m_ph, IR, NZCV)});
            chk("model_retired", {16'd0, retired}, {16'd0, m_ret});
        end
    end

    // ---------------- directed stimulus ----------------
    int         t_len;
    logic [3:0] e_alu;
    logic [1:0] e_rs;
    logic [2:0] e_sh;
    logic       e_rm, e_s, saw_wreg, saw_undef, saw_lf;

    // Called with the FSM in FETCH; returns one cycle after the final state.
    task automatic run_instr(input logic [31:0] ir, input logic [3:0] f);
        bit fin;
        IR = ir; NZCV = f;
        t_len = 0; fin = 0;
        {e_alu, e_rs, e_sh, e_rm, e_s, saw_wreg, saw_undef, saw_lf} = '0;
        for (int i = 0; i < 12 && !fin; i++) begin
            @(negedge clk);
            t_len++;
            if (state == 3'd3) begin
                e_alu = ALU_OP; e_rs = rs_imm_s; e_sh = SHIFT_OP; e_rm = rm_imm_s; e_s = S;
            end
            if (Write_Reg) saw_wreg = 1'b1;
            if (LF) saw_lf = 1'b1;
            if (undef) saw_undef = 1'b1;
            if (instr_done || undef) fin = 1;
        end
        if (!fin) chk("instr_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] r_save;
        bit fin;
        rst_n = 1'b0; run = 1'b0; IR = 32'd0; NZCV = 4'd0;
        #2;
        chk("reset_outs", {9'd0, w_outs}, 32'd0);
        chk("reset_retired", {16'd0, retired}, 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1;
        chk("start_fetch", {29'd0, state}, 32'd1);

        run_instr(32'hE0812003, 4'b0000);
        chk("add_len", t_len, 4);
        chk("add_alu", {28'd0, e_alu}, 32'h4);
        chk("add_rs", {30'd0, e_rs}, 32'h1);
        chk("add_sh", {29'd0, e_sh}, 32'h0);
        chk("add_rm_s", {30'd0, e_rm, e_s}, 32'h0);
        chk("add_wreg", {31'd0, saw_wreg}, 32'd1);
        chk("add_retired", {16'd0, retired}, 32'd1);

        run_instr(32'hE3A01005, 4'b0000);
        chk("mov_len", t_len, 4);
        chk("mov_sel", {25'd0, e_rm, e_rs, e_sh}, {25'd0, 1'b1, 2'b10, 3'b111});
        chk("mov_alu", {28'd0, e_alu}, 32'hD);

        run_instr(32'hE1510002, 4'b0000);
        chk("cmp_len", t_len, 3);
        chk("cmp_s_alu", {27'd0, e_s, e_alu}, {27'd0, 1'b1, 4'hA});
        chk("cmp_no_wreg", {31'd0, saw_wreg}, 32'd0);
        chk("cmp_next_fetch", {29'd0, state}, 32'd1);

        run_instr(32'h00810003, 4'b0000);
        chk("addeq_fail_len", t_len, 2);
        chk("addeq_fail_lf", {31'd0, saw_lf}, 32'd0);
        run_instr(32'h00810003, 4'b0100);
        chk("addeq_pass_len", t_len, 4);

        run_instr(32'hE0821311, 4'b0000);
        chk("regshift_sel", {27'd0, e_rs, e_sh}, {27'd0, 2'b00, 3'b001});

        r_save = retired;
        run_instr(32'hEA000000, 4'b0000);
        chk("undef_seen", {31'd0, saw_undef}, 32'd1);
        chk("undef_len", t_len, 2);
        chk("undef_retired", {16'd0, retired}, {16'd0, r_save});

        run_instr(32'hC0812003, 4'b1001);
        chk("gt_pass_len", t_len, 4);
        run_instr(32'hC0812003, 4'b1000);
        chk("gt_fail_len", t_len, 2);
        run_instr(32'hF0812003, 4'b1111);
        chk("nv_len", t_len, 2);
        chk("retired_9", {16'd0, retired}, 32'd9);

        // Asynchronous reset in the middle of EXEC.
        IR = 32'hE0812003; NZCV = 4'b0000; fin = 0;
        for (int i = 0; i < 8 && !fin; i++) begin
            @(negedge clk);
            if (state == 3'd3) fin = 1;
        end
        if (!fin) chk("exec_timeout", 32'd0, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_outs", {9'd0, w_outs}, 32'd0);
        chk("midreset_retired", {16'd0, retired}, 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("restart_fetch", {29'd0, state}, 32'd1);
        run_instr(32'hE3A01005, 4'b0000);
        chk("restart_retired", {16'd0, retired}, 32'd1);

        // Drop run during DECODE: finish the instruction, then park.
        IR = 32'hE0812003;
        @(posedge clk); #1 run = 1'b0;
        chk("decode_state", {29'd0, state}, 32'd2);
        fin = 0;
        for (int i = 0; i < 8 && !fin; i++) begin
            @(negedge clk);
            if (instr_done) fin = 1;
        end
        if (!fin) chk("park_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        chk("parked_idle", {29'd0, state}, 32'd0);
        repeat (3) @(negedge clk);
        chk("parked_hold", {29'd0, state}, 32'd0);
        chk("final_retired", {16'd0, retired}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
